// File: rtl/tq_transpose_buf.sv
//------------------------------------------------------------------------------
// tq_transpose_buf : NxN coefficient transpose buffer between rec_tq passes.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tq_transpose_buf #(
  parameter int W     = 28,
  parameter int LANES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dt_vld,
  input  logic [1:0]         i_transize,
  input  logic [LANES*W-1:0] i_data,
  output logic               o_ready,
  output logic               o_drop,
  output logic               o_dt_vld,
  output logic [1:0]         o_transize,
  output logic [LANES*W-1:0] o_data
);

  localparam int CW = $clog2(LANES);
  localparam int NW = CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       row_cnt_q;
  logic [CW-1:0]       col_cnt_q;
  logic [1:0]          n_code_q;
  logic [W-1:0]        mem_q [LANES][LANES];

  logic [NW-1:0]       n_cur;
  logic [CW-1:0]       last_idx;
  logic                wr_en;
  logic [CW-1:0]       wr_row;
  logic [NW-1:0]       wr_n;
  logic [LANES*W-1:0]  col_d;

  assign n_cur    = NW'(4) << n_code_q;
  assign last_idx = CW'(n_cur - NW'(1));
  assign o_ready  = (state_q != READ);

  // The first beat of a block uses the live size pin; later beats use the latched size.
  assign wr_en  = i_dt_vld && (state_q != READ) && !rst;
  assign wr_row = (state_q == IDLE) ? '0 : row_cnt_q;
  assign wr_n   = (state_q == IDLE) ? (NW'(4) << i_transize) : n_cur;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        if (NW'(j) < wr_n) begin
          mem_q[wr_row][j] <= i_data[j*W +: W];
        end
      end
    end
  end

  always_comb begin
    col_d = '0;
    for (int r = 0; r < LANES; r++) begin
      if (NW'(r) < n_cur) begin
        col_d[r*W +: W] = mem_q[r][col_cnt_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      n_code_q   <= '0;
      o_drop     <= 1'b0;
      o_dt_vld   <= 1'b0;
      o_transize <= '0;
      o_data     <= '0;
    end else begin
      o_drop <= i_dt_vld && (state_q == READ);
      case (state_q)
        IDLE: begin
          o_dt_vld <= 1'b0;
          o_data   <= '0;
          if (i_dt_vld) begin
            n_code_q  <= i_transize;
            row_cnt_q <= CW'(1);
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (i_dt_vld) begin
            row_cnt_q <= row_cnt_q + CW'(1);
            if (row_cnt_q == last_idx) begin
              col_cnt_q <= '0;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          o_data     <= col_d;
          o_dt_vld   <= 1'b1;
          o_transize <= n_code_q;
          col_cnt_q  <= col_cnt_q + CW'(1);
          if (col_cnt_q == last_idx) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
